ex_mem_stage: RTL

- Parametrised successor to the EX/MEM pipeline register.
- Adds a valid/ready handshake with a one-entry skid buffer, plus stall and flush.
- Fully decodes byte, half and word loads and stores into lane byte-enables, replicated store data and load-extension control.
- Sits between the EX stage and the MEM stage / data-memory interface.

---
 rtl/ex_mem_stage.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: valid/ready handshake with a one-entry skid buffer, flush,
// and full byte/half/word load-store decode. Optional MISALIGN_TRAP_EN suppresses misaligned accesses.
module ex_mem_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned OP_W       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [OP_W-1:0]           ex_memOp,
  input  logic [ADDR_W-1:0]         ex_memAddr,
  input  logic [REG_ADDR_W-1:0]     ex_regDest,
  input  logic [DATA_W-1:0]         ex_value,
  input  logic [DATA_W-1:0]         ex_storeData,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic                      mem_memWriteEnable,
  output logic                      mem_memReadEnable,
  output logic [ADDR_W-1:0]         mem_memAddr,
  output logic [DATA_W/8-1:0]       mem_memSel,
  output logic [DATA_W-1:0]         mem_memWdata,
  output logic                      mem_loadSigned,
  output logic [1:0]                mem_loadSize,
  output logic                      mem_regWriteEnable,
  output logic [REG_ADDR_W-1:0]     mem_regDest,
  output logic [DATA_W-1:0]         mem_value,
  output logic                      mem_valSel,
  output logic                      mem_misalign
);

  localparam int unsigned LANES  = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(LANES);

  localparam logic [OP_W-1:0] OP_WRITE_REG = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LB        = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LBU       = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LH        = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LHU       = OP_W'(5);
  localparam logic [OP_W-1:0] OP_LW        = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SB        = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SH        = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SW        = OP_W'(9);

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic                  we;
    logic                  re;
    logic [ADDR_W-1:0]     addr;
    logic [LANES-1:0]      sel;
    logic [DATA_W-1:0]     wdata;
    logic                  load_signed;
    logic [1:0]            load_size;
    logic                  rwe;
    logic [REG_ADDR_W-1:0] rdest;
    logic [DATA_W-1:0]     value;
    logic                  val_sel;
    logic                  misalign;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, dec;
  logic   main_v, main_v_d, skid_v, skid_v_d, ready_q;
  logic   accept, drain;
  logic   is_load, is_store, is_byte, is_half, is_word;
  logic [LANE_W-1:0] lane, lane_h, lane_w;

  assign accept = ex_valid && ready_q;
  assign drain  = main_v && mem_ready;

  // Decode the incoming op into the entry format held by main/skid
  always_comb begin
    dec      = '0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    lane     = ex_memAddr[LANE_W-1:0];
    lane_h   = lane & ~LANE_W'(1);
    lane_w   = lane & ~LANE_W'(3);

    case (ex_memOp)
      OP_WRITE_REG: begin
        dec.rwe   = 1'b1;
        dec.rdest = ex_regDest;
        dec.value = ex_value;
        dec.addr  = ex_memAddr;
      end
      OP_LB:  begin is_load = 1'b1; is_byte = 1'b1; dec.load_signed = 1'b1; end
      OP_LBU: begin is_load = 1'b1; is_byte = 1'b1; end
      OP_LH:  begin is_load = 1'b1; is_half = 1'b1; dec.load_signed = 1'b1; end
      OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
      OP_LW:  begin is_load = 1'b1; is_word = 1'b1; end
      OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
      OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:  begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase

    if (is_load || is_store) begin
      dec.addr = ex_memAddr;
      if (is_byte)      dec.sel = LANES'(1) << lane;
      else if (is_half) dec.sel = LANES'(3) << lane_h;
      else              dec.sel = LANES'(15) << lane_w;
    end

    if (is_load) begin
      dec.re        = 1'b1;
      dec.rwe       = 1'b1;
      dec.val_sel   = 1'b1;
      dec.rdest     = ex_regDest;
      dec.load_size = is_byte ? SIZE_BYTE : (is_half ? SIZE_HALF : SIZE_WORD);
    end

    if (is_store) begin
      dec.we = 1'b1;
      if (is_byte)      dec.wdata = {LANES{ex_storeData[7:0]}};
      else if (is_half) dec.wdata = {(LANES/2){ex_storeData[15:0]}};
      else              dec.wdata = {(DATA_W/32){ex_storeData[31:0]}};
    end

    // x0 is never written back, but the op still issues
    if (ex_regDest == '0) dec.rwe = 1'b0;

`ifdef MISALIGN_TRAP_EN
    if ((is_half && ex_memAddr[0]) || (is_word && (ex_memAddr[1:0] != 2'b00))) begin
      dec.misalign = 1'b1;
      dec.we       = 1'b0;
      dec.re       = 1'b0;
      dec.rwe      = 1'b0;
      dec.sel      = '0;
    end
`else
    dec.misalign = 1'b0;
`endif
  end

  // Main/skid next state; flush beats accept and drain
  always_comb begin
    main_d   = main_q;
    main_v_d = main_v;
    skid_d   = skid_q;
    skid_v_d = skid_v;
    if (flush) begin
      main_d   = '0;
      main_v_d = 1'b0;
      skid_d   = '0;
      skid_v_d = 1'b0;
    end else if (!main_v) begin
      if (accept) begin
        main_d   = dec;
        main_v_d = 1'b1;
      end
    end else if (drain) begin
      if (skid_v) begin
        main_d   = skid_q;
        skid_d   = '0;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d = dec;
      end else begin
        main_d   = '0;
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = dec;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q  <= '0;
      main_v  <= 1'b0;
      skid_q  <= '0;
      skid_v  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      main_q  <= main_d;
      main_v  <= main_v_d;
      skid_q  <= skid_d;
      skid_v  <= skid_v_d;
      ready_q <= !skid_v_d;
    end
  end

  assign ex_ready           = ready_q;
  assign mem_valid          = main_v;
  assign mem_memWriteEnable = main_q.we;
  assign mem_memReadEnable  = main_q.re;
  assign mem_memAddr        = main_q.addr;
  assign mem_memSel         = main_q.sel;
  assign mem_memWdata       = main_q.wdata;
  assign mem_loadSigned     = main_q.load_signed;
  assign mem_loadSize       = main_q.load_size;
  assign mem_regWriteEnable = main_q.rwe;
  assign mem_regDest        = main_q.rdest;
  assign mem_value          = main_q.value;
  assign mem_valSel         = main_q.val_sel;
  assign mem_misalign       = main_q.misalign;

endmodule
